mdl_bdsio_endpoint: RTL and testbench
=====================================

Name: mdl_bdsio_endpoint

Overview:
Bubble-side serial data endpoint for the 005297 bubble data path: the device end of the serial bubble data link.
- Page read: sources the bubble read stream (MSB first) that the controller shifts into its DMA data byte register.
- Page write: sinks the effective bubble write stream the controller shifts out, packing it into bytes.
- Page storage: holds one page in a register-array buffer with a host/bench load and inspect port.
- Use: simulation top and FPGA core stand-in for the bubble cartridge data loops.

Parameters:
- PAGE_BYTES, 64, bytes per page transferred per start command.
- AW, 6, buffer/byte-counter address width; must satisfy 2^AW >= PAGE_BYTES.

Ports:
- i_MCLK  in  1  master clock
- i_RST  in  1  synchronous active-high reset
- i_CLK2M_PCEN_n  in  1  bit-tick enable, active low; all bit activity happens only on i_MCLK edges with this low
- i_RD_START  in  1  start page read (endpoint -> controller), sampled in IDLE
- i_WR_START  in  1  start page write (controller -> endpoint), sampled in IDLE
- i_ABORT  in  1  terminate current transfer
- o_BDI  out  1  serial bubble read data to controller, MSB first
- i_BDO  in  1  serial bubble write data from controller, MSB first
- o_BUSY  out  1  transfer in progress
- o_DONE  out  1  one-MCLK pulse at normal page completion
- i_HOST_WE  in  1  buffer write strobe
- i_HOST_ADDR  in  AW  buffer byte address
- i_HOST_D  in  8  buffer write data
- o_HOST_Q  out  8  buffer read data, combinational from i_HOST_ADDR
- o_CRC  out  16  running/final CRC (see Optional Feature)

Behaviour:
- One clock (i_MCLK); reset synchronous active-high.
- States: IDLE, READ, WRITE. Registers: 8-bit shift reg sr, 3-bit bitcnt, AW-bit bytecnt.
- Reset: state=IDLE, sr=0, bitcnt=0, bytecnt=0, o_BDI=0, o_BUSY=0, o_DONE=0, o_CRC=16'hFFFF when the CRC feature is compiled in. Buffer contents are not reset.
- IDLE:
  - i_RD_START=1: sr<=buf[0], bytecnt<=0, bitcnt<=0, go READ.
  - else i_WR_START=1: sr<=0, counters<=0, go WRITE.
  - Both asserted: READ wins.
  - Starts take effect on any MCLK edge; no tick is required.
- o_BDI = sr[7] in READ, 0 otherwise. It is stable between ticks; the controller samples the pre-shift value on the same tick edge.
- READ, per tick:
  - bitcnt<7: sr<=sr<<1, bitcnt++.
  - bitcnt==7 and bytecnt<PAGE_BYTES-1: sr<=buf[bytecnt+1], bytecnt++, bitcnt<=0.
  - bitcnt==7 and bytecnt==PAGE_BYTES-1: go IDLE, o_DONE<=1.
- WRITE, per tick:
  - sr<={sr[6:0],i_BDO}, bitcnt++.
  - bitcnt==7: buf[bytecnt]<={sr[6:0],i_BDO}, bytecnt++, bitcnt<=0.
  - That tick on byte PAGE_BYTES-1: go IDLE, o_DONE<=1.
- Latency: the first bit is on o_BDI one MCLK after the start edge. o_DONE is high for exactly the MCLK cycle after the final tick edge.
- o_BUSY = (state != IDLE).
- i_ABORT while busy: next edge goes IDLE, counters cleared, partial WRITE byte discarded (buffer untouched), no o_DONE. i_ABORT in IDLE is ignored. i_ABORT has priority over a coincident tick and over start.
- Start strobes while busy are ignored.
- i_HOST_WE takes effect only in IDLE and is ignored while busy. o_HOST_Q is always valid.
- Ticks in IDLE do nothing.

Optional Feature:
- Macro: MDL_BDSIO_CRC_EN.
- Defined:
  - CRC-16-CCITT (poly 0x1021, MSB first, no reflection, no final XOR) runs over every transferred bit: o_BDI in READ, i_BDO in WRITE.
  - Updated on the same tick edge the bit is consumed.
  - Preset to 16'hFFFF on reset and on each accepted start.
  - Holds after DONE or ABORT until the next start.
- Undefined: o_CRC tied to 16'h0000 and no CRC logic is built.

Test Plan:
- Reset: assert i_RST for 4 MCLKs mid-READ -> o_BUSY=0, o_BDI=0, o_DONE=0; buffer byte loaded earlier is unchanged via o_HOST_Q.
- Read: buf[0]=8'hA5, buf[1]=8'h3C, RD_START -> o_BDI before ticks 1..16 = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0. o_DONE is a single pulse the cycle after tick 512 (PAGE_BYTES=64); o_BUSY falls the same cycle.
- Write: WR_START, drive i_BDO with 8'hC3 then 8'h5A MSB first -> buf[0]=8'hC3, buf[1]=8'h5A via o_HOST_Q after o_DONE.
- Abort: in WRITE, with buf[1]=8'h77 preloaded, assert i_ABORT after 12 ticks -> o_BUSY=0 next cycle, no o_DONE, buf[1]=8'h77.
- Contention: RD_START+WR_START together in IDLE -> READ entered. WR_START and i_HOST_WE issued during READ -> ignored; state and buffer unchanged.
- CRC (macro defined, PAGE_BYTES=9, buffer "123456789" ASCII): full READ -> o_CRC=16'h29B1 after o_DONE. Macro undefined -> o_CRC=16'h0000.

Source files
------------

// File: rtl/mdl_bdsio_endpoint.sv
// ---------------------------------------------------------------------------
// mdl_bdsio_endpoint
// Device end of the 005297 serial bubble data link. It holds one page in a
// register-array buffer. It sources that page MSB first on o_BDI for a page
// read, and it packs the i_BDO stream back into the buffer for a page write.
// All bit activity is paced by the active-low bit-tick enable i_CLK2M_PCEN_n.
//
// Optional build macro: MDL_BDSIO_CRC_EN
//   defined   : a CRC-16-CCITT (0x1021, MSB first, preset FFFF) runs over every
//               transferred bit and is presented on o_CRC.
//   undefined : o_CRC is tied to 16'h0000 and no CRC logic is built.
//
// Ports
//   i_MCLK          master clock
//   i_RST           synchronous active-high reset
//   i_CLK2M_PCEN_n  bit-tick enable, active low
//   i_RD_START      start page read (buffer -> o_BDI), sampled in IDLE
//   i_WR_START      start page write (i_BDO -> buffer), sampled in IDLE
//   i_ABORT         terminate the current transfer (no o_DONE)
//   o_BDI           serial read data, MSB first, 0 outside READ
//   i_BDO           serial write data, MSB first
//   o_BUSY          transfer in progress
//   o_DONE          one-MCLK pulse after the final tick of a full page
//   i_HOST_WE       buffer write strobe, honoured only in IDLE
//   i_HOST_ADDR     buffer byte address
//   i_HOST_D        buffer write data
//   o_HOST_Q        buffer read data, combinational from i_HOST_ADDR
//   o_CRC           running/final CRC, or 0 when the CRC is not built
//
// Handshake: a start strobe is accepted on any MCLK edge while IDLE, with
// read winning over write. Once busy, one bit moves per MCLK edge that sees
// i_CLK2M_PCEN_n low. i_ABORT outranks a coincident tick and any start.
// ---------------------------------------------------------------------------
module mdl_bdsio_endpoint #(
  parameter int PAGE_BYTES = 64,
  parameter int AW         = 6
) (
  input  logic          i_MCLK,
  input  logic          i_RST,
  input  logic          i_CLK2M_PCEN_n,
  input  logic          i_RD_START,
  input  logic          i_WR_START,
  input  logic          i_ABORT,
  output logic          o_BDI,
  input  logic          i_BDO,
  output logic          o_BUSY,
  output logic          o_DONE,
  input  logic          i_HOST_WE,
  input  logic [AW-1:0] i_HOST_ADDR,
  input  logic [7:0]    i_HOST_D,
  output logic [7:0]    o_HOST_Q,
  output logic [15:0]   o_CRC
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [AW-1:0] LAST_BYTE = AW'(PAGE_BYTES - 1);

  logic [1:0]    r_state;
  logic [7:0]    r_sr;
  logic [2:0]    r_bitcnt;
  logic [AW-1:0] r_bytecnt;
  logic          r_done;
  logic [7:0]    r_buf [PAGE_BYTES];

  logic          w_tick;
  logic          w_busy;
  logic          w_bit_tick;
  logic          w_byte_end;
  logic          w_last_byte;
  logic [AW-1:0] w_next_byte;
  logic [7:0]    w_wr_byte;
  logic          w_buf_we;
  logic [AW-1:0] w_buf_waddr;
  logic [7:0]    w_buf_wdata;

  assign w_tick      = ~i_CLK2M_PCEN_n;
  assign w_busy      = (r_state != ST_IDLE);
  // A bit is consumed only on a tick that is not overridden by an abort.
  assign w_bit_tick  = w_busy & w_tick & ~i_ABORT;
  assign w_byte_end  = (r_bitcnt == 3'd7);
  assign w_last_byte = (r_bytecnt == LAST_BYTE);
  assign w_next_byte = r_bytecnt + AW'(1);
  assign w_wr_byte   = {r_sr[6:0], i_BDO};

  assign o_BUSY   = w_busy;
  assign o_DONE   = r_done;
  assign o_BDI    = (r_state == ST_READ) & r_sr[7];
  assign o_HOST_Q = r_buf[i_HOST_ADDR];

  // Single buffer write port: the host owns it in IDLE, the serial sink owns
  // it at each completed byte of a WRITE. The two can never coincide.
  always_comb begin
    w_buf_we    = 1'b0;
    w_buf_waddr = i_HOST_ADDR;
    w_buf_wdata = i_HOST_D;
    if (r_state == ST_IDLE) begin
      w_buf_we = i_HOST_WE;
    end else if ((r_state == ST_WRITE) && w_bit_tick && w_byte_end) begin
      w_buf_we    = 1'b1;
      w_buf_waddr = r_bytecnt;
      w_buf_wdata = w_wr_byte;
    end
  end

  // Buffer contents survive reset on purpose.
  always_ff @(posedge i_MCLK) begin
    if (w_buf_we) begin
      r_buf[w_buf_waddr] <= w_buf_wdata;
    end
  end

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      r_state   <= ST_IDLE;
      r_sr      <= 8'h00;
      r_bitcnt  <= 3'd0;
      r_bytecnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_RD_START) begin
            r_sr      <= r_buf[0];
            r_bitcnt  <= 3'd0;
            r_bytecnt <= '0;
            r_state   <= ST_READ;
          end else if (i_WR_START) begin
            r_sr      <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_bytecnt <= '0;
            r_state   <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (i_ABORT) begin
            r_state   <= ST_IDLE;
            r_sr      <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_bytecnt <= '0;
          end else if (w_tick) begin
            if (!w_byte_end) begin
              r_sr     <= {r_sr[6:0], 1'b0};
              r_bitcnt <= r_bitcnt + 3'd1;
            end else if (!w_last_byte) begin
              r_sr      <= r_buf[w_next_byte];
              r_bytecnt <= w_next_byte;
              r_bitcnt  <= 3'd0;
            end else begin
              r_state   <= ST_IDLE;
              r_done    <= 1'b1;
              r_bitcnt  <= 3'd0;
              r_bytecnt <= '0;
            end
          end
        end
        ST_WRITE: begin
          if (i_ABORT) begin
            // Partial byte in r_sr is dropped; the buffer is not touched.
            r_state   <= ST_IDLE;
            r_sr      <= 8'h00;
            r_bitcnt  <= 3'd0;
            r_bytecnt <= '0;
          end else if (w_tick) begin
            r_sr     <= w_wr_byte;
            r_bitcnt <= r_bitcnt + 3'd1;  // wraps 7 -> 0 at byte end
            if (w_byte_end) begin
              if (w_last_byte) begin
                r_state   <= ST_IDLE;
                r_done    <= 1'b1;
                r_bytecnt <= '0;
              end else begin
                r_bytecnt <= w_next_byte;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MDL_BDSIO_CRC_EN
  logic        w_serial_bit;
  logic        w_crc_fb;
  logic [15:0] w_crc_next;
  logic [15:0] r_crc;

  // The bit on the wire this tick: the pre-shift o_BDI when reading, i_BDO
  // when writing.
  assign w_serial_bit = (r_state == ST_READ) ? r_sr[7] : i_BDO;
  assign w_crc_fb     = r_crc[15] ^ w_serial_bit;
  assign w_crc_next   = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? 16'h1021 : 16'h0000);

  // Holds after DONE/ABORT until the next accepted start re-presets it.
  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      r_crc <= 16'hFFFF;
    end else if ((r_state == ST_IDLE) && (i_RD_START || i_WR_START)) begin
      r_crc <= 16'hFFFF;
    end else if (w_bit_tick) begin
      r_crc <= w_crc_next;
    end
  end

  assign o_CRC = r_crc;
`else
  assign o_CRC = 16'h0000;
`endif

endmodule

// File: tb/tb_mdl_bdsio_endpoint.sv
// ---------------------------------------------------------------------------
// tb_mdl_bdsio_endpoint
// Randomized self-checking bench for mdl_bdsio_endpoint. A byte-array page
// model predicts the serial read stream, the buffer after writes and the CRC;
// expectations are queued at stimulus time and a negedge monitor pops and
// compares them when the DUT presents the corresponding output.
// With MDL_BDSIO_CRC_EN defined the bench uses a 9-byte page so that the
// "123456789" check value 16'h29B1 can be exercised.
// ---------------------------------------------------------------------------
module tb_mdl_bdsio_endpoint;

`ifdef MDL_BDSIO_CRC_EN
  localparam int PB  = 9;
  localparam int AWB = 4;
`else
  localparam int PB  = 64;
  localparam int AWB = 6;
`endif

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst;
  logic            pcen_n;
  logic            rd_start;
  logic            wr_start;
  logic            abort;
  logic            bdi;
  logic            bdo;
  logic            busy;
  logic            done;
  logic            host_we;
  logic [AWB-1:0]  host_addr;
  logic [7:0]      host_d;
  logic [7:0]      host_q;
  logic [15:0]     crc;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mdl_bdsio_endpoint #(.PAGE_BYTES(PB), .AW(AWB)) dut (
    .i_MCLK         (clk),
    .i_RST          (rst),
    .i_CLK2M_PCEN_n (pcen_n),
    .i_RD_START     (rd_start),
    .i_WR_START     (wr_start),
    .i_ABORT        (abort),
    .o_BDI          (bdi),
    .i_BDO          (bdo),
    .o_BUSY         (busy),
    .o_DONE         (done),
    .i_HOST_WE      (host_we),
    .i_HOST_ADDR    (host_addr),
    .i_HOST_D       (host_d),
    .o_HOST_Q       (host_q),
    .o_CRC          (crc)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [0:0]  exp_bit_q[$];
  logic [7:0]  exp_q[$];
  logic [15:0] exp_crc_q[$];
  logic [2:0]  exp_st_q[$];
  int          exp_done_q[$];
  bit          host_chk = 1'b0;
  bit          st_chk   = 1'b0;
  bit          crc_chk  = 1'b0;
  bit          rd_mode  = 1'b0;

  // ---------------- reference model ----------------
  logic [7:0]  mem     [PB];
  logic [7:0]  wr_data [PB];
  logic [15:0] m_crc = 16'hFFFF;

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [15:0] crc_exp(input logic [15:0] m);
`ifdef MDL_BDSIO_CRC_EN
    return m;
`else
    return 16'h0000 & m;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!pcen_n && busy && rd_mode && !abort && !rst) begin
      if (exp_bit_q.size() == 0) chk("bdi_unexpected_tick", 32'd1, 32'd0);
      else chk("bdi", {31'd0, bdi}, {31'd0, exp_bit_q.pop_front()});
    end
    if (done) begin
      if (exp_done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else chk("done_cycle", cyc, exp_done_q.pop_front());
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end
    if (host_chk) begin
      if (exp_q.size() == 0) chk("host_q_noexp", 32'd1, 32'd0);
      else chk("host_q", {24'd0, host_q}, {24'd0, exp_q.pop_front()});
    end
    if (st_chk) begin
      if (exp_st_q.size() == 0) chk("status_noexp", 32'd1, 32'd0);
      else chk("status{busy,bdi,done}", {29'd0, busy, bdi, done}, {29'd0, exp_st_q.pop_front()});
    end
    if (crc_chk) begin
      if (exp_crc_q.size() == 0) chk("crc_noexp", 32'd1, 32'd0);
      else chk("crc", {16'd0, crc}, {16'd0, exp_crc_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [AWB-1:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_d = d;
    mem[a] = d;
    step();
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [AWB-1:0] a);
    host_addr = a;
    exp_q.push_back(mem[a]);
    host_chk = 1'b1;
    step();
    host_chk = 1'b0;
  endtask

  task automatic status(input logic eb, input logic ed, input logic edn);
    exp_st_q.push_back({eb, ed, edn});
    st_chk = 1'b1;
    step();
    st_chk = 1'b0;
  endtask

  task automatic crc_check(input logic [15:0] e);
    exp_crc_q.push_back(e);
    crc_chk = 1'b1;
    step();
    crc_chk = 1'b0;
  endtask

  // One bit tick after 0..2 idle cycles; the final tick books its DONE cycle.
  task automatic do_tick(input logic b, input bit last);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      pcen_n = 1'b1;
      step();
    end
    bdo = b;
    pcen_n = 1'b0;
    if (last) exp_done_q.push_back(cyc + 1);
    step();
    pcen_n = 1'b1;
  endtask

  task automatic page_read(input int abort_at, input int inject_at, input bit both);
    int total;
    total = PB * 8;
    rd_start = 1'b1; wr_start = both;
    step();
    rd_start = 1'b0; wr_start = 1'b0;
    rd_mode = 1'b1;
    m_crc = 16'hFFFF;
    if (both) status(1'b1, mem[0][7], 1'b0);
    for (int n = 0; n < total; n++) begin
      logic b;
      if (n == abort_at) begin
        abort = 1'b1;
        pcen_n = 1'($urandom_range(0, 1));
        wr_start = 1'b1;
        step();
        abort = 1'b0; wr_start = 1'b0; pcen_n = 1'b1;
        rd_mode = 1'b0;
        status(1'b0, 1'b0, 1'b0);
        break;
      end
      b = mem[n / 8][7 - (n % 8)];
      exp_bit_q.push_back(b);
      m_crc = crc_bit(m_crc, b);
      if (n == inject_at) begin
        wr_start = 1'b1; host_we = 1'b1; host_addr = AWB'(3); host_d = ~mem[3];
      end
      do_tick(1'($urandom), n == total - 1);
      wr_start = 1'b0; host_we = 1'b0;
      if (n == total - 1) begin
        rd_mode = 1'b0;
        status(1'b0, 1'b0, 1'b1);
        status(1'b0, 1'b0, 1'b0);
      end
    end
    chk("bits_consumed", exp_bit_q.size(), 32'd0);
    crc_check(crc_exp(m_crc));
  endtask

  task automatic page_write(input int abort_at);
    int total;
    total = PB * 8;
    wr_start = 1'b1;
    step();
    wr_start = 1'b0;
    m_crc = 16'hFFFF;
    for (int n = 0; n < total; n++) begin
      logic b;
      if (n == abort_at) begin
        abort = 1'b1;
        pcen_n = 1'($urandom_range(0, 1));
        rd_start = 1'b1;
        step();
        abort = 1'b0; rd_start = 1'b0; pcen_n = 1'b1;
        status(1'b0, 1'b0, 1'b0);
        break;
      end
      b = wr_data[n / 8][7 - (n % 8)];
      m_crc = crc_bit(m_crc, b);
      do_tick(b, n == total - 1);
      if (n % 8 == 7) mem[n / 8] = wr_data[n / 8];
      if (n == total - 1) begin
        status(1'b0, 1'b0, 1'b1);
        status(1'b0, 1'b0, 1'b0);
      end
    end
    crc_check(crc_exp(m_crc));
    for (int i = 0; i < PB; i++) host_read(AWB'(i));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; pcen_n = 1'b1; rd_start = 1'b0; wr_start = 1'b0; abort = 1'b0;
    bdo = 1'b0; host_we = 1'b0; host_addr = '0; host_d = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    status(1'b0, 1'b0, 1'b0);
    crc_check(crc_exp(16'hFFFF));

    // Load the page, with the two documented read bytes up front.
    for (int i = 0; i < PB; i++) host_write(AWB'(i), 8'($urandom));
    host_write(AWB'(0), 8'hA5);
    host_write(AWB'(1), 8'h3C);
    for (int i = 0; i < 4; i++) host_read(AWB'($urandom_range(0, PB - 1)));

    // Ticks and abort in IDLE are ignored; CRC holds.
    pcen_n = 1'b0; abort = 1'b1;
    repeat (3) step();
    pcen_n = 1'b1; abort = 1'b0;
    status(1'b0, 1'b0, 1'b0);
    crc_check(crc_exp(16'hFFFF));

    // Full page read.
    page_read(-1, -1, 1'b0);

    // Page write starting with C3, 5A.
    for (int i = 0; i < PB; i++) wr_data[i] = 8'($urandom);
    wr_data[0] = 8'hC3;
    wr_data[1] = 8'h5A;
    page_write(-1);

    // Abort in WRITE after 12 ticks; byte 1 preloaded with 77 must survive.
    host_write(AWB'(1), 8'h77);
    for (int i = 0; i < PB; i++) wr_data[i] = 8'($urandom);
    page_write(12);

    // Both starts together -> READ; WR_START and host write during READ ignored.
    page_read(-1, 5, 1'b1);
    host_read(AWB'(3));

    // Abort in READ part way.
    page_read($urandom_range(1, PB * 8 - 1), -1, 1'b0);

    // Reset mid-READ.
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    rd_mode = 1'b1;
    for (int n = 0; n < 20; n++) begin
      exp_bit_q.push_back(mem[n / 8][7 - (n % 8)]);
      do_tick(1'b0, 1'b0);
    end
    rst = 1'b1;
    rd_mode = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    chk("bits_consumed_rst", exp_bit_q.size(), 32'd0);
    status(1'b0, 1'b0, 1'b0);
    crc_check(crc_exp(16'hFFFF));
    host_read(AWB'(0));
    host_read(AWB'(1));

`ifdef MDL_BDSIO_CRC_EN
    // Standard check string "123456789".
    host_write(AWB'(0), 8'h31); host_write(AWB'(1), 8'h32); host_write(AWB'(2), 8'h33);
    host_write(AWB'(3), 8'h34); host_write(AWB'(4), 8'h35); host_write(AWB'(5), 8'h36);
    host_write(AWB'(6), 8'h37); host_write(AWB'(7), 8'h38); host_write(AWB'(8), 8'h39);
    page_read(-1, -1, 1'b0);
    crc_check(16'h29B1);
`endif

    // Random mix of transfers, some aborted.
    repeat (4) begin
      int ab;
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, PB * 8 - 1) : -1;
      if ($urandom_range(0, 1) == 0) begin
        page_read(ab, -1, 1'b0);
      end else begin
        for (int i = 0; i < PB; i++) wr_data[i] = 8'($urandom);
        page_write(ab);
      end
    end

    repeat (4) step();
    chk("done_pending", exp_done_q.size(), 32'd0);
    chk("bits_pending", exp_bit_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
